alu_issue: RTL and testbench
============================

# alu_issue

Instruction issue stage feeding the 16-bit register-file ALU. It holds a small writable program memory of 29-bit ALU instructions and steps a program counter through it. Each instruction is presented to the ALU's INST input for a fixed number of clock cycles, so the ALU's operand-read, execute and write-back delays complete before the next change. It also counts issued instructions and the overflows the ALU reports back.

## Interface
- IMEM_DEPTH, 64: program memory words; power of two, 2..256
- PC_W, 6: PC width; equals log2(IMEM_DEPTH)
- HOLD_CYCLES, 4: cycles each instruction is held on inst; minimum 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled only in IDLE or DONE
- prog_we  in  1  program memory write strobe; ignored while busy
- prog_addr  in  PC_W  program write address
- prog_data  in  29  program write data, in ALU instruction format
- ovf_in  in  1  ALU Over_Flow output
- inst  out  29  instruction driven to ALU INST
- inst_valid  out  1  high while inst carries a real program instruction
- pc  out  PC_W  address of the current or next instruction
- busy  out  1  high in FETCH/HOLD
- done  out  1  high in DONE
- issue_cnt  out  16  instructions issued since last start; wraps at 16'hFFFF
- ovf_cnt  out  8  overflows seen since last start; saturates at 8'hFF

## Operation
- Instruction format: [28:24] op_code, [23:20] dest, [19:16] src1, [15:12] src2 or [15:0] imm (op_code[0]=1).
- Halt instruction: op_code 5'b11111. The halt instruction is never presented to the ALU.
- States:
  - IDLE: start -> FETCH, with pc, issue_cnt and ovf_cnt cleared.
  - FETCH: synchronous read of imem[pc] -> HOLD, or -> DONE if the word is a halt.
  - HOLD: inst is stable for HOLD_CYCLES cycles. On the last cycle, ovf_in is sampled, pc is incremented, and the state -> FETCH. If pc was IMEM_DEPTH-1, the state -> DONE instead and pc does not wrap.
  - DONE: start -> FETCH, with pc and counters cleared.
- Repeat guard: if the fetched word equals the word currently on inst, 29'h0 (AND r0,r0,r0) is first presented for HOLD_CYCLES cycles with inst_valid=0. The real word follows in a second HOLD. Without this, the ALU would not see an edge and the repeated instruction would be lost. The NOP is not counted in issue_cnt.
- inst changes only at HOLD entry. Its value is retained in FETCH, DONE and IDLE.
- issue_cnt increments at HOLD entry for real instructions.
- ovf_cnt increments when ovf_in=1 on the last HOLD cycle of a real instruction.
- prog_we in IDLE/DONE writes prog_data to imem[prog_addr] at the clock edge. prog_we in FETCH/HOLD is dropped.
- The memory contents are not reset.

## Timing
- Reset (async assert, sync-effective deassert at the next edge):
  - state IDLE
  - inst 29'h0, inst_valid 0, pc 0
  - busy 0, done 0
  - issue_cnt 0, ovf_cnt 0
- start high at edge N: FETCH in cycle N+1. inst updates at edge N+2, with inst_valid=1.
- Each instruction takes HOLD_CYCLES+1 cycles; each repeat-guarded instruction takes 2*HOLD_CYCLES+1.
- After a halt is fetched, done rises one cycle after FETCH.
- start and prog_we in the same cycle in IDLE/DONE: the write completes and the run starts. The new word is visible if it is at pc 0.
- Reset mid-HOLD: all outputs return to reset values immediately. The ALU then sees inst go to 29'h0.

## Configuration
- ALU_ISSUE_OVF_HALT_EN defined:
  - ovf_in=1 sampled on a real instruction forces -> DONE after that instruction.
  - pc keeps the address of the offending instruction.
  - A sticky ovf_halt output (1 bit, reset 0, cleared on start) is added.
- Undefined: overflow is only counted, execution continues, and the ovf_halt port does not exist.

## Test plan
- Load ADD r3,r1,r2 at 0 and halt at 1, start -> inst=29'h0431_2000 for exactly 4 cycles, then done=1, issue_cnt=1, pc=1.
- Two identical words at 0 and 1 -> inst sequence word, 29'h0 with inst_valid=0, word; issue_cnt=2.
- ovf_in=1 during instruction 2 of 3, macro undefined -> ovf_cnt=1, all 3 issued. Macro defined -> done after instruction 2, pc=1, ovf_halt=1.
- Fill all 64 words with non-halt instructions -> 64 issues, done after pc=63, no wrap to 0.
- Assert rst_n low mid-HOLD -> inst, pc and counters are 0 at once. prog_we while busy -> memory unchanged on readback run.

Source files
------------

// File: rtl/alu_issue.sv
// Instruction issue stage for the 16-bit register-file ALU: program memory, PC sequencer,
// repeat guard and issue/overflow counters. Optional ALU_ISSUE_OVF_HALT_EN stops a run on overflow.
module alu_issue #(
  parameter int IMEM_DEPTH  = 64,
  parameter int PC_W        = 6,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [28:0]     prog_data,
  input  logic            ovf_in,
  output logic [28:0]     inst,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic [15:0]     issue_cnt,
  output logic [7:0]      ovf_cnt
`ifdef ALU_ISSUE_OVF_HALT_EN
  ,
  output logic            ovf_halt
`endif
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [28:0]     imem [IMEM_DEPTH];
  logic [28:0]     fetch_word;
  logic [HC_W-1:0] hold_cnt;
  logic            nop_active;
  logic            is_halt;
  logic            is_repeat;
  logic            last_hold;
  logic            at_end;
  logic            launch;
  logic            ovf_stop;

  assign fetch_word = imem[pc];
  assign is_halt    = (fetch_word[28:24] == 5'h1F);
  assign is_repeat  = (fetch_word == inst);
  assign last_hold  = (hold_cnt == HC_W'(HOLD_CYCLES - 1));
  assign at_end     = (pc == PC_W'(IMEM_DEPTH - 1));
  assign launch     = ((state == IDLE) || (state == DONE)) && start;
  assign busy       = (state == FETCH) || (state == HOLD);
  assign done       = (state == DONE);

`ifdef ALU_ISSUE_OVF_HALT_EN
  assign ovf_stop = ovf_in;
`else
  assign ovf_stop = 1'b0;
`endif

  // NOTE: the program store has no reset so it maps onto plain RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) imem[prog_addr] <= prog_data;
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE: if (start) state_d = FETCH;
      FETCH:      state_d = is_halt ? DONE : HOLD;
      HOLD: begin
        if (last_hold && !nop_active) state_d = (at_end || ovf_stop) ? DONE : FETCH;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      pc         <= '0;
      issue_cnt  <= '0;
      ovf_cnt    <= '0;
      hold_cnt   <= '0;
      nop_active <= 1'b0;
`ifdef ALU_ISSUE_OVF_HALT_EN
      ovf_halt   <= 1'b0;
`endif
    end else begin
      if (launch) begin
        pc        <= '0;
        issue_cnt <= '0;
        ovf_cnt   <= '0;
`ifdef ALU_ISSUE_OVF_HALT_EN
        ovf_halt  <= 1'b0;
`endif
      end

      if (state == FETCH && !is_halt) begin
        // A repeated word is preceded by a NOP so the ALU sees an edge on INST.
        inst       <= is_repeat ? 29'h0 : fetch_word;
        inst_valid <= !is_repeat;
        nop_active <= is_repeat;
        hold_cnt   <= '0;
        if (!is_repeat) issue_cnt <= issue_cnt + 16'd1;
      end

      if (state == HOLD) begin
        if (!last_hold) begin
          hold_cnt <= hold_cnt + HC_W'(1);
        end else if (nop_active) begin
          inst       <= fetch_word;
          inst_valid <= 1'b1;
          nop_active <= 1'b0;
          hold_cnt   <= '0;
          issue_cnt  <= issue_cnt + 16'd1;
        end else begin
          inst_valid <= 1'b0;
          if (ovf_in && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
`ifdef ALU_ISSUE_OVF_HALT_EN
          if (ovf_in) ovf_halt <= 1'b1;
`endif
          if (!at_end && !ovf_stop) pc <= pc + PC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: predicted INST presentations are queued at start and
// popped as the DUT presents them; run length, counters and final PC are checked per run.
module tb_alu_issue;
  localparam int H  = 4;
  localparam int D  = 64;
  localparam int PW = 6;
  localparam logic [28:0] HALT = 29'h1F00_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [PW-1:0] prog_addr = '0;
  logic [28:0]   prog_data = '0;
  logic          ovf_in;
  logic [28:0]   inst;
  logic          inst_valid;
  logic [PW-1:0] pc;
  logic          busy;
  logic          done;
  logic [15:0]   issue_cnt;
  logic [7:0]    ovf_cnt;
`ifdef ALU_ISSUE_OVF_HALT_EN
  logic          ovf_halt;
`endif

  alu_issue #(.IMEM_DEPTH(D), .PC_W(PW), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .ovf_in(ovf_in),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .busy(busy), .done(done),
    .issue_cnt(issue_cnt), .ovf_cnt(ovf_cnt)
`ifdef ALU_ISSUE_OVF_HALT_EN
    , .ovf_halt(ovf_halt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [28:0] word;
    logic        nop;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [28:0] mem_model [D];
  logic [28:0] model_inst = 29'h0;
  logic        ovf_arm = 1'b0;
  logic [28:0] ovf_word = 29'h0;
  bit          mon_en = 1'b0;

  // ALU stand-in: reports overflow while the chosen word is presented.
  assign ovf_in = ovf_arm && inst_valid && (inst == ovf_word);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input logic is_nop);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(is_nop ? "nop_inst" : "issue_inst", {3'b0, inst}, {3'b0, e.word});
      check("issue_kind", {31'b0, is_nop}, {31'b0, e.nop});
    end
  endtask

  // Presentation monitor: a real word starts when inst_valid rises, a NOP when inst drops to 0.
  logic        prev_valid;
  logic [28:0] prev_inst;
  int          run_len, nop_len;
  bit          in_nop;
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_valid = 1'b0; prev_inst = inst; run_len = 0; nop_len = 0; in_nop = 1'b0;
    end else begin
      if (inst_valid && !prev_valid) begin
        if (in_nop) check("nop_len", nop_len, H);
        in_nop = 1'b0;
        pop_check(1'b0);
        run_len = 1;
      end else if (inst_valid) begin
        run_len++;
      end else begin
        if (prev_valid) check("hold_len", run_len, H);
        if (busy && inst == 29'h0 && inst != prev_inst) begin
          pop_check(1'b1);
          in_nop = 1'b1;
          nop_len = 1;
        end else if (in_nop) begin
          nop_len++;
        end
      end
      prev_valid = inst_valid;
      prev_inst  = inst;
    end
  end

  task automatic predict(output int cyc, output int iss, output int fpc, output int ovc);
    int p;
    logic [28:0] w;
    p = 0; cyc = 0; iss = 0; fpc = 0; ovc = 0;
    forever begin
      w = mem_model[p];
      cyc++;
      if (w[28:24] == 5'h1F) begin fpc = p; break; end
      if (w == model_inst) begin
        sb.push_back('{word: 29'h0, nop: 1'b1});
        cyc += H;
      end
      sb.push_back('{word: w, nop: 1'b0});
      cyc += H;
      iss++;
      model_inst = w;
      if (ovf_arm && w == ovf_word) begin
        ovc++;
`ifdef ALU_ISSUE_OVF_HALT_EN
        fpc = p;
        break;
`endif
      end
      if (p == D - 1) begin fpc = p; break; end
      p++;
    end
  endtask

  task automatic wr(input logic [PW-1:0] a, input logic [28:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic run(input string tag, input bit with_we, input logic [PW-1:0] a,
                     input logic [28:0] d);
    int cyc, iss, fpc, ovc, n;
    @(negedge clk);
    if (with_we) begin
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      mem_model[a] = d;
    end
    predict(cyc, iss, fpc, ovc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_cycles"}, n, cyc);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_issue_cnt"}, {16'b0, issue_cnt}, iss);
    check({tag, "_pc"}, {26'b0, pc}, fpc);
    check({tag, "_ovf_cnt"}, {24'b0, ovf_cnt}, ovc);
    check({tag, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", {3'b0, inst}, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_pc", {26'b0, pc}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_issue", {16'b0, issue_cnt}, 32'd0);
    check("rst_ovf", {24'b0, ovf_cnt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;

    // ADD r3,r1,r2 written in the same cycle as start, halt at 1.
    wr(6'd1, HALT);
    run("add_halt", 1'b1, 6'd0, 29'h0431_2000);
    check("add_halt_pc_lit", {26'b0, pc}, 32'd1);

    // Identical consecutive words exercise the repeat guard.
    wr(6'd0, 29'h0254_3000);
    wr(6'd1, 29'h0254_3000);
    wr(6'd2, HALT);
    run("repeat", 1'b0, '0, '0);
    check("repeat_issue_lit", {16'b0, issue_cnt}, 32'd2);

    // Overflow reported on the second of three instructions.
    wr(6'd0, 29'h0231_2000);
    wr(6'd1, 29'h0452_1000);
    wr(6'd2, 29'h0673_4000);
    wr(6'd3, HALT);
    ovf_arm = 1'b1; ovf_word = 29'h0452_1000;
    run("ovf", 1'b0, '0, '0);
`ifdef ALU_ISSUE_OVF_HALT_EN
    check("ovf_halt_set", {31'b0, ovf_halt}, 32'd1);
`endif
    ovf_arm = 1'b0;

    // Full memory with no halt: runs to the last word and stops without wrapping.
    for (int i = 0; i < D; i++) wr(PW'(i), 29'h0010_0000 + 29'(i));
    run("fill", 1'b0, '0, '0);
`ifdef ALU_ISSUE_OVF_HALT_EN
    check("ovf_halt_clear", {31'b0, ovf_halt}, 32'd0);
`endif

    // Write attempt while busy, then reset in the middle of a HOLD.
    mon_en = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 6'd0; prog_data = HALT;
    @(posedge clk); #1 prog_we = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", {31'b0, busy}, 32'd1);
    check("mid_valid", {31'b0, inst_valid}, 32'd1);
    check("mid_pc", {26'b0, pc}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_inst", {3'b0, inst}, 32'h0);
    check("mid_rst_pc", {26'b0, pc}, 32'd0);
    check("mid_rst_issue", {16'b0, issue_cnt}, 32'd0);
    check("mid_rst_ovf", {24'b0, ovf_cnt}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_inst = 29'h0;
    mon_en = 1'b1;

    // Readback: memory must still hold the full fill program.
    run("readback", 1'b0, '0, '0);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
